// File: rtl/mac_array_gen.sv
// mac_array_gen: systolic COL x PR signed MAC array; each Q vector ripples across the columns, one psum per column.
// Define MAC_ARRAY_SAT_EN to clamp each psum to PSUM_BW instead of wrapping.
module mac_array_gen #(
  parameter int COL     = 8,
  parameter int PR      = 8,
  parameter int BW      = 8,
  parameter int PSUM_BW = 22
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PR*BW-1:0]       in,
  input  logic [1:0]             inst,
  output logic [COL*PSUM_BW-1:0] out,
  output logic [COL-1:0]         fifo_wr,
  output logic                   busy,
  output logic                   k_full
);
  localparam int FW = 2*BW + $clog2(PR);
  localparam int AW = FW > PSUM_BW ? FW : PSUM_BW;
  localparam int PW = COL > 1 ? $clog2(COL) : 1;

  logic [PR*BW-1:0]       k_q [COL];
  logic [PR*BW-1:0]       q_q [COL];
  logic [COL-1:0]         v_q, v_d, wr_q;
  logic [PW-1:0]          k_ptr_q;
  logic                   k_full_q, busy_q, k_last;
  logic [COL*PSUM_BW-1:0] out_q, out_d;

  function automatic logic signed [AW-1:0] dot(input logic [PR*BW-1:0] k, input logic [PR*BW-1:0] q);
    logic signed [AW-1:0] s;
    s = '0;
    for (int i = 0; i < PR; i++)
      s = s + AW'($signed(k[i*BW +: BW])) * AW'($signed(q[i*BW +: BW]));
    return s;
  endfunction

  function automatic logic [PSUM_BW-1:0] fit(input logic signed [AW-1:0] s);
`ifdef MAC_ARRAY_SAT_EN
    logic signed [AW-1:0] hi, lo;
    hi = {{(AW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    lo = ~hi;
    return s > hi ? hi[PSUM_BW-1:0] : (s < lo ? lo[PSUM_BW-1:0] : s[PSUM_BW-1:0]);
`else
    return s[PSUM_BW-1:0];
`endif
  endfunction

  assign k_last = k_ptr_q == PW'(COL-1);
  // Valid bits shift one column per edge; a new one enters on execute.
  assign v_d    = COL'({v_q, inst == 2'b10});

  // Each column reads K[c] live, so a reload ahead of an in-flight vector affects it.
  always_comb begin
    out_d = out_q;
    for (int c = 0; c < COL; c++)
      if (v_q[c]) out_d[c*PSUM_BW +: PSUM_BW] = fit(dot(k_q[c], q_q[c]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < COL; c++) begin
        k_q[c] <= '0;
        q_q[c] <= '0;
      end
      v_q      <= '0;
      wr_q     <= '0;
      k_ptr_q  <= '0;
      k_full_q <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      if (inst == 2'b01) begin
        k_q[k_ptr_q] <= in;
        k_ptr_q      <= k_last ? '0 : k_ptr_q + 1'b1;
        k_full_q     <= k_full_q | k_last;
      end else if (inst == 2'b11) begin
        k_ptr_q  <= '0;
        k_full_q <= 1'b0;
      end
      if (inst == 2'b10) q_q[0] <= in;
      for (int c = 1; c < COL; c++) q_q[c] <= q_q[c-1];
      v_q    <= v_d;
      wr_q   <= v_q;
      busy_q <= |v_d;
      out_q  <= out_d;
    end
  end

  assign out     = out_q;
  assign fifo_wr = wr_q;
  assign busy    = busy_q;
  assign k_full  = k_full_q;
endmodule

// File: tb/tb_mac_array_gen.sv
// tb_mac_array_gen: scoreboard bench for mac_array_gen; a second instance with PSUM_BW=16 exercises wrap/saturation.
module tb_mac_array_gen;
  localparam int COL = 8, PR = 8, BW = 8, PSUM_BW = 22, PS16 = 16;
`ifdef MAC_ARRAY_SAT_EN
  localparam logic [PS16-1:0] BIG16 = 16'h7fff;
`else
  localparam logic [PS16-1:0] BIG16 = 16'h0000;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic [PR*BW-1:0] in = '0, in16 = '0;
  logic [1:0] inst = 2'b00, inst16 = 2'b00;
  logic [COL*PSUM_BW-1:0] out;
  logic [COL*PS16-1:0] out16;
  logic [COL-1:0] fifo_wr, wr16;
  logic busy, k_full, busy16, kf16;

  int total = 0, bad = 0;
  logic [PR*BW-1:0] mk [COL];
  int ptr = 0;
  logic [PSUM_BW-1:0] exp_q [COL][$];
  logic [PSUM_BW-1:0] mon_e;
  bit mon_en = 1'b0;
  int cyc = 0;
  int wcnt [COL], wfirst [COL], wlast [COL];

  always #5 clk = ~clk;

  mac_array_gen #(.COL(COL), .PR(PR), .BW(BW), .PSUM_BW(PSUM_BW)) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .inst(inst),
    .out(out), .fifo_wr(fifo_wr), .busy(busy), .k_full(k_full));

  mac_array_gen #(.COL(COL), .PR(PR), .BW(BW), .PSUM_BW(PS16)) u16 (
    .clk(clk), .reset_n(reset_n), .in(in16), .inst(inst16),
    .out(out16), .fifo_wr(wr16), .busy(busy16), .k_full(kf16));

  function automatic longint dot(input logic [PR*BW-1:0] k, input logic [PR*BW-1:0] q);
    longint s = 0;
    for (int i = 0; i < PR; i++)
      s += longint'($signed(k[i*BW +: BW])) * longint'($signed(q[i*BW +: BW]));
    return s;
  endfunction

  function automatic logic [PR*BW-1:0] fill(input int x);
    logic [PR*BW-1:0] v;
    for (int i = 0; i < PR; i++) v[i*BW +: BW] = BW'(x);
    return v;
  endfunction

  function automatic logic [PR*BW-1:0] rnd();
    logic [PR*BW-1:0] v;
    for (int i = 0; i < PR; i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < COL; c++) n += exp_q[c].size();
    return n;
  endfunction

  // Scoreboard: every strobe pops the column's oldest expected psum.
  always @(negedge clk) begin
    cyc++;
    if (mon_en)
      for (int c = 0; c < COL; c++)
        if (fifo_wr[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL strobe col%0d: unexpected fifo_wr, out=%h", c, out[c*PSUM_BW +: PSUM_BW]);
          end else begin
            mon_e = exp_q[c].pop_front();
            if (out[c*PSUM_BW +: PSUM_BW] !== mon_e) begin
              bad++;
              $display("FAIL psum col%0d: got %h expected %h", c, out[c*PSUM_BW +: PSUM_BW], mon_e);
            end
          end
          if (wcnt[c] == 0) wfirst[c] = cyc;
          wlast[c] = cyc;
          wcnt[c]++;
        end
  end

  task automatic step(input logic [1:0] op, input logic [PR*BW-1:0] v);
    inst = op;
    in = v;
    @(negedge clk);
    inst = 2'b00;
  endtask

  task automatic step16(input logic [1:0] op, input logic [PR*BW-1:0] v);
    inst16 = op;
    in16 = v;
    @(negedge clk);
    inst16 = 2'b00;
  endtask

  task automatic load(input logic [PR*BW-1:0] v);
    step(2'b01, v);
    mk[ptr] = v;
    ptr = (ptr + 1) % COL;
  endtask

  task automatic clear_k();
    step(2'b11, '0);
    ptr = 0;
  endtask

  task automatic exec(input logic [PR*BW-1:0] v);
    for (int c = 0; c < COL; c++) exp_q[c].push_back(PSUM_BW'(dot(mk[c], v)));
    step(2'b10, v);
  endtask

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", pending());
      for (int c = 0; c < COL; c++) exp_q[c].delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < COL; c++) mk[c] = '0;
    #1;
    total += 4;
    if (out !== '0) begin bad++; $display("FAIL reset_out: got %h expected 0", out); end
    if (fifo_wr !== '0) begin bad++; $display("FAIL reset_wr: got %b expected 0", fifo_wr); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (k_full !== 1'b0) begin bad++; $display("FAIL reset_kfull: got %b expected 0", k_full); end
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [COL-1:0] ew;
    for (int c = 0; c < COL; c++) load(fill(c + 1));
    total++;
    if (k_full !== 1'b1) begin bad++; $display("FAIL basic_kfull: got %b expected 1", k_full); end
    exec(fill(1));
    total++;
    if (fifo_wr !== '0) begin bad++; $display("FAIL latency_n0: got %b expected 0", fifo_wr); end
    for (int n = 1; n <= COL + 1; n++) begin
      step(2'b00, '0);
      ew = n <= COL ? COL'(1) << (n - 1) : '0;
      total++;
      if (fifo_wr !== ew) begin bad++; $display("FAIL latency_n%0d: got %b expected %b", n, fifo_wr, ew); end
    end
    drain();
    for (int c = 0; c < COL; c++) begin
      total++;
      if (out[c*PSUM_BW +: PSUM_BW] !== PSUM_BW'(PR*(c+1))) begin
        bad++;
        $display("FAIL hold col%0d: got %0d expected %0d", c, out[c*PSUM_BW +: PSUM_BW], PR*(c+1));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_k();
    for (int c = 0; c < COL; c++) load(rnd());
    for (int c = 0; c < COL; c++) wcnt[c] = 0;
    for (int j = 0; j < 8; j++) exec(rnd());
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_hi: got %b expected 1", busy); end
    drain();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_lo: got %b expected 0", busy); end
    for (int c = 0; c < COL; c++) begin
      total++;
      if (wcnt[c] != 8 || wlast[c] - wfirst[c] != 7) begin
        bad++;
        $display("FAIL b2b_run col%0d: got %0d strobes over %0d cycles, expected 8 over 8", c, wcnt[c], wlast[c] - wfirst[c] + 1);
      end
    end
  endtask

  task automatic test_wrap();
    clear_k();
    for (int j = 1; j <= 10; j++) begin
      load(rnd());
      if (j == 7 || j == 8 || j == 10) begin
        total++;
        if (k_full !== (j >= 8)) begin bad++; $display("FAIL wrap_kfull_load%0d: got %b expected %b", j, k_full, j >= 8); end
      end
    end
    exec(rnd());
    drain();
    clear_k();
    total++;
    if (k_full !== 1'b0) begin bad++; $display("FAIL clear_kfull: got %b expected 0", k_full); end
    exec(rnd());
    drain();
  endtask

  task automatic test_async_reset();
    int strobes = 0;
    for (int c = 0; c < COL; c++) load(rnd());
    exec(rnd());
    for (int j = 0; j < 3; j++) step(2'b00, '0);
    #2 reset_n = 1'b0;
    #1;
    total += 4;
    if (out !== '0) begin bad++; $display("FAIL areset_out: got %h expected 0", out); end
    if (fifo_wr !== '0) begin bad++; $display("FAIL areset_wr: got %b expected 0", fifo_wr); end
    if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
    if (k_full !== 1'b0) begin bad++; $display("FAIL areset_kfull: got %b expected 0", k_full); end
    for (int c = 0; c < COL; c++) begin
      exp_q[c].delete();
      mk[c] = '0;
    end
    ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step(2'b00, '0);
      if (fifo_wr !== '0) strobes++;
    end
    total++;
    if (strobes != 0) begin bad++; $display("FAIL areset_quiet: got %0d strobe cycles expected 0", strobes); end
    load(rnd());
    exec(rnd());
    drain();
  endtask

  task automatic test_sat();
    for (int c = 0; c < COL; c++) begin
      load(fill(-128));
      step16(2'b01, fill(-128));
    end
    exec(fill(-128));
    drain();
    step16(2'b10, fill(1));
    for (int j = 0; j < COL + 2; j++) step16(2'b00, '0);
    for (int c = 0; c < COL; c++) begin
      total++;
      if (out16[c*PS16 +: PS16] !== 16'hfc00) begin bad++; $display("FAIL small16 col%0d: got %h expected fc00", c, out16[c*PS16 +: PS16]); end
    end
    step16(2'b10, fill(-128));
    for (int j = 0; j < COL + 2; j++) step16(2'b00, '0);
    for (int c = 0; c < COL; c++) begin
      total++;
      if (out16[c*PS16 +: PS16] !== BIG16) begin bad++; $display("FAIL big16 col%0d: got %h expected %h", c, out16[c*PS16 +: PS16], BIG16); end
    end
  endtask

  task automatic test_reload();
    logic [PR*BW-1:0] newk, q;
    clear_k();
    for (int c = 0; c < 5; c++) load(rnd());
    newk = ~mk[5];
    q = rnd();
    mk[5] = newk;
    exec(q);
    step(2'b00, '0);
    step(2'b00, '0);
    step(2'b01, newk);
    ptr = 6;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_sat();
    test_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
